// File: rtl/scan_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// scan_pkg : channel-count constants and FSM state encoding for scan_sequencer
// Rev 1.0
// ============================================================================
package scan_pkg;

  localparam int SEL_W = 3;
  localparam int NCHAN = 2 ** SEL_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/scan_sequencer_next_chan_finder.sv
`default_nettype none
// ============================================================================
// next_chan_finder : lowest set mask bit above cur, plus lowest set bit overall
// Rev 1.0
// ============================================================================
module next_chan_finder
  import scan_pkg::*;
(
  input  logic [NCHAN-1:0] mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             wrap,
  output logic [SEL_W-1:0] first
);

  // Scanning downward lets the last hit win, which is the lowest qualifying bit.
  always_comb begin
    nxt   = '0;
    wrap  = 1'b1;
    first = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first = SEL_W'(i);
        if (i > int'(cur)) begin
          nxt  = SEL_W'(i);
          wrap = 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
// scan_sequencer : steps sel/en through enabled channels with dwell + blanking
// Rev 1.0
// ============================================================================
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [NCHAN-1:0]   chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               en,
  output logic               busy,
  output logic               chan_strobe,
  output logic               sweep_done
);

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [NCHAN-1:0]   mask_q, mask_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   nxt_q, nxt_d;
  logic               wrap_q, wrap_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               strobe_q, strobe_d;
  logic               done_q, done_d;

  logic [DWELL_W-1:0] dwell_eff;
  logic [NCHAN-1:0]   find_mask;
  logic [SEL_W-1:0]   find_nxt;
  logic [SEL_W-1:0]   find_first;
  logic               find_wrap;

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  // While ACTIVE the finder looks ahead in the latched mask; otherwise it
  // finds the first channel of the live mask for a start or restart.
  assign find_mask = (state_q == ACTIVE) ? mask_q : chan_mask;

  next_chan_finder u_finder (
    .mask  (find_mask),
    .cur   (sel_q),
    .nxt   (find_nxt),
    .wrap  (find_wrap),
    .first (find_first)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    mask_d   = mask_q;
    sel_d    = sel_q;
    nxt_d    = nxt_q;
    wrap_d   = wrap_q;
    en_d     = 1'b0;
    strobe_d = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop && (chan_mask != '0)) begin
          state_d  = ACTIVE;
          mask_d   = chan_mask;
          dwell_d  = dwell_eff;
          cnt_d    = dwell_eff;
          sel_d    = find_first;
          en_d     = 1'b1;
          strobe_d = 1'b1;
        end
      end

      ACTIVE: begin
        nxt_d  = find_nxt;
        wrap_d = find_wrap;
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q <= DWELL_W'(1)) begin
          state_d = BLANK;
          done_d  = find_wrap;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
          en_d  = 1'b1;
        end
      end

      BLANK: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!wrap_q) begin
          state_d  = ACTIVE;
          sel_d    = nxt_q;
          cnt_d    = dwell_q;
          en_d     = 1'b1;
          strobe_d = 1'b1;
        end else if (continuous && (chan_mask != '0)) begin
          state_d  = ACTIVE;
          mask_d   = chan_mask;
          dwell_d  = dwell_eff;
          cnt_d    = dwell_eff;
          sel_d    = find_first;
          en_d     = 1'b1;
          strobe_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dwell_q  <= '0;
      mask_q   <= '0;
      sel_q    <= '0;
      nxt_q    <= '0;
      wrap_q   <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      mask_q   <= mask_d;
      sel_q    <= sel_d;
      nxt_q    <= nxt_d;
      wrap_q   <= wrap_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign sel         = sel_q;
  assign en          = en_q;
  assign busy        = busy_q;
  assign chan_strobe = strobe_q;
  assign sweep_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_sequencer.sv
`default_nettype none
// ============================================================================
// tb_scan_sequencer : vector table, corner sequences and randomized model check
// Rev 1.0
// ============================================================================
module tb_scan_sequencer;

  localparam int DW = 16;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          start      = 1'b0;
  logic          stop       = 1'b0;
  logic          continuous = 1'b0;
  logic [7:0]    chan_mask  = 8'h00;
  logic [DW-1:0] dwell      = '0;
  logic [2:0]    sel;
  logic          en;
  logic          busy;
  logic          chan_strobe;
  logic          sweep_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .continuous  (continuous),
    .chan_mask   (chan_mask),
    .dwell       (dwell),
    .sel         (sel),
    .en          (en),
    .busy        (busy),
    .chan_strobe (chan_strobe),
    .sweep_done  (sweep_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Sticky flag: en high on adjacent cycles with a different sel.
  logic       prev_en     = 1'b0;
  logic [2:0] prev_sel    = 3'd0;
  logic       glitch_seen = 1'b0;
  always @(negedge clk) begin
    if (prev_en && en && (prev_sel != sel)) glitch_seen <= 1'b1;
    prev_en  <= en;
    prev_sel <= sel;
  end

  typedef struct {
    logic [7:0]    mask;
    logic [DW-1:0] dwell;
    int            done_cyc;
    int            strobes;
    int            first_sel;
    int            last_sel;
  } sweep_vec_t;

  sweep_vec_t vecs [6];

  // Caller is at a negedge; cycle 0 is the one where start is presented.
  task automatic run_sweep(input sweep_vec_t t, input int idx);
    int nstrobe = 0;
    int fsel    = -1;
    int lsel    = -1;
    int dcyc    = -1;
    chan_mask  = t.mask;
    dwell      = t.dwell;
    continuous = 1'b0;
    start      = 1'b1;
    for (int c = 1; c <= 200 && dcyc < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (chan_strobe) begin
        nstrobe++;
        if (fsel < 0) fsel = int'(sel);
        lsel = int'(sel);
      end
      if (sweep_done) dcyc = c;
    end
    check($sformatf("vec%0d_done_cycle", idx), dcyc, t.done_cyc);
    check($sformatf("vec%0d_strobes", idx), nstrobe, t.strobes);
    check($sformatf("vec%0d_first_sel", idx), fsel, t.first_sel);
    check($sformatf("vec%0d_last_sel", idx), lsel, t.last_sel);
    @(negedge clk);
    check($sformatf("vec%0d_busy_after", idx), busy, 0);
    check($sformatf("vec%0d_en_after", idx), en, 0);
  endtask

  task automatic count_activity(input int ncyc, output int act);
    act = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (en || busy || chan_strobe || sweep_done) act++;
    end
  endtask

  // Reference model: a sweep is a flat timeline of n channels x P cycles.
  bit         m_on   = 1'b0;
  logic [7:0] m_mask = 8'h00;
  int         m_p    = 2;
  int         m_n    = 0;
  int         m_k    = 0;
  logic [2:0] m_sel  = 3'd0;
  logic       e_en, e_busy, e_strobe, e_done;

  function automatic int nth_set(input logic [7:0] m, input int n);
    int cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        if (cnt == n) return i;
        cnt++;
      end
    end
    return 0;
  endfunction

  task automatic model_latch();
    m_mask = chan_mask;
    m_p    = ((dwell == '0) ? 1 : int'(dwell)) + 1;
    m_n    = $countones(chan_mask);
    m_k    = 0;
  endtask

  task automatic model_step();
    int idx, ph;
    if (!m_on) begin
      if (start && !stop && (chan_mask != 8'h00)) begin
        m_on = 1'b1;
        model_latch();
      end
    end else if (stop) begin
      m_on = 1'b0;
    end else begin
      m_k++;
      if (m_k == m_n * m_p) begin
        if (continuous && (chan_mask != 8'h00)) model_latch();
        else m_on = 1'b0;
      end
    end
    if (m_on) begin
      idx      = m_k / m_p;
      ph       = m_k % m_p;
      m_sel    = 3'(nth_set(m_mask, idx));
      e_en     = (ph < m_p - 1);
      e_strobe = (ph == 0);
      e_done   = (idx == m_n - 1) && (ph == m_p - 1);
      e_busy   = 1'b1;
    end else begin
      e_en     = 1'b0;
      e_strobe = 1'b0;
      e_done   = 1'b0;
      e_busy   = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int act;
    int found;

    vecs[0] = '{mask: 8'hFF, dwell: 16'd3, done_cyc: 32, strobes: 8, first_sel: 0, last_sel: 7};
    vecs[1] = '{mask: 8'hA4, dwell: 16'd0, done_cyc: 6,  strobes: 3, first_sel: 2, last_sel: 7};
    vecs[2] = '{mask: 8'h01, dwell: 16'd2, done_cyc: 3,  strobes: 1, first_sel: 0, last_sel: 0};
    vecs[3] = '{mask: 8'h80, dwell: 16'd1, done_cyc: 2,  strobes: 1, first_sel: 7, last_sel: 7};
    vecs[4] = '{mask: 8'h81, dwell: 16'd5, done_cyc: 12, strobes: 2, first_sel: 0, last_sel: 7};
    vecs[5] = '{mask: 8'h18, dwell: 16'd0, done_cyc: 4,  strobes: 2, first_sel: 3, last_sel: 4};

    repeat (2) @(negedge clk);
    check("reset_sel", sel, 0);
    check("reset_en", en, 0);
    check("reset_busy", busy, 0);
    check("reset_strobe", chan_strobe, 0);
    check("reset_done", sweep_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) run_sweep(vecs[v], v);

    // Asynchronous reset while ACTIVE on sel=1.
    chan_mask = 8'hFF; dwell = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_sel", sel, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_sel", sel, 0);
    check("async_reset_en", en, 0);
    check("async_reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_activity(10, act);
    check("post_reset_quiet", act, 0);

    // Continuous single-channel sweeps, mask changed mid-sweep.
    chan_mask = 8'h01; dwell = 16'd2; continuous = 1'b1; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("cont_done_c%0d", c), sweep_done, (c % 3 == 0));
      if (c == 8)  check("cont_old_mask_sel", {en, sel}, {1'b1, 3'd0});
      if (c == 10) check("cont_new_mask_sel", {en, sel}, {1'b1, 3'd7});
      if (c == 7)  chan_mask = 8'h80;
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; continuous = 1'b0;
    check("cont_stop_busy", busy, 0);

    // Stop while ACTIVE on sel=4.
    chan_mask = 8'hFF; dwell = 16'd3; start = 1'b1;
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (en && sel == 3'd4) found = 1;
    end
    check("stop_reached_sel4", found, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_en", en, 0);
    check("stop_busy", busy, 0);
    check("stop_sel_hold", sel, 4);
    check("stop_no_done", sweep_done, 0);
    count_activity(40, act);
    check("stop_quiet", act, 0);

    // start and stop together.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    count_activity(6, act);
    check("start_stop_idle", act, 0);

    // start with an empty mask.
    chan_mask = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_activity(6, act);
    check("empty_mask_idle", act, 0);

    // Randomized run against the timeline model, from a fresh reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_on = 1'b0; m_sel = 3'd0;
    for (int c = 0; c < 800; c++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0)
        chan_mask = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 9) == 0) dwell = DW'($urandom_range(0, 4));
      if ($urandom_range(0, 29) == 0) continuous = ~continuous;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check($sformatf("rand_c%0d", c), {sel, en, busy, chan_strobe, sweep_done},
            {m_sel, e_en, e_busy, e_strobe, e_done});
    end

    check("no_en_glitch", glitch_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
